// File: rtl/gin_tag_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gin_tag_issuer
// Purpose  : Stamps a global-buffer word stream with tile-scan row/column tags
//            and presents each word on the GIN enable/ready input port.
// Revision : 1.0 - initial release
// ============================================================================
module gin_tag_issuer #(
    parameter int ROW_LEN   = 4,
    parameter int ID_LEN    = 5,
    parameter int VALUE_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN-1:0]   row_base,
    input  logic [ID_LEN-1:0]    col_base,
    input  logic [ROW_LEN-1:0]   num_rows,
    input  logic [ID_LEN-1:0]    num_cols,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VALUE_LEN-1:0] in_data,
    output logic                 gin_enable,
    input  logic                 gin_ready,
    output logic [ROW_LEN-1:0]   gin_row_tag,
    output logic [ID_LEN-1:0]    gin_col_tag,
    output logic [VALUE_LEN-1:0] gin_value
);

    localparam int CNT_LEN = ROW_LEN + ID_LEN;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [ID_LEN-1:0]    col_base_q;
    logic [ID_LEN-1:0]    num_cols_q;
    logic [ROW_LEN-1:0]   row_cnt;
    logic [ID_LEN-1:0]    col_cnt;
    logic [CNT_LEN-1:0]   remaining;

    logic                 out_free;
    logic                 accept;
    logic [ID_LEN-1:0]    col_last;

    // Output register can take a new word if empty or retiring this cycle.
    assign out_free = !gin_enable || gin_ready;
    assign in_ready = (state == S_ISSUE) && out_free;
    assign accept   = in_valid && in_ready;
    assign col_last = col_base_q + num_cols_q - ID_LEN'(1);

    // Row base and row count are consumed at start into row_cnt/remaining;
    // only the column wrap bounds are needed for the rest of the scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            col_base_q  <= '0;
            num_cols_q  <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            gin_enable  <= 1'b0;
            gin_row_tag <= '0;
            gin_col_tag <= '0;
            gin_value   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col_base_q <= col_base;
                        num_cols_q <= num_cols;
                        row_cnt    <= row_base;
                        col_cnt    <= col_base;
                        remaining  <= CNT_LEN'(num_rows) * CNT_LEN'(num_cols);
                        busy       <= 1'b1;
                        if ((num_rows == '0) || (num_cols == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (accept) begin
                        gin_value   <= in_data;
                        gin_row_tag <= row_cnt;
                        gin_col_tag <= col_cnt;
                        gin_enable  <= 1'b1;
                        remaining   <= remaining - CNT_LEN'(1);
                        if (col_cnt == col_last) begin
                            col_cnt <= col_base_q;
                            row_cnt <= row_cnt + ROW_LEN'(1);
                        end else begin
                            col_cnt <= col_cnt + ID_LEN'(1);
                        end
                        if (remaining == CNT_LEN'(1)) begin
                            state <= S_DRAIN;
                        end
                    end else if (gin_enable && gin_ready) begin
                        gin_enable <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (out_free) begin
                        gin_enable <= 1'b0;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/gin_tag_issuer.md
Name: gin_tag_issuer

Overview:
- Upstream feeder for the global interconnect network (GIN) input port.
- Accepts a ready/valid stream of data words from the global buffer read path.
- Stamps each word with a row tag (Y-bus) and column tag (X-bus) from tile-scan counters.
- Presents each word on the GIN enable/ready slave interface, holding it stable until the GIN accepts it.

Parameters:
- ROW_LEN, 4, width of row tag; must match GIN ROW_LEN.
- ID_LEN, 5, width of column tag; must match GIN ID_LEN.
- VALUE_LEN, 32, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a tile scan; sampled only in IDLE.
- row_base  in  ROW_LEN  first row tag of tile.
- col_base  in  ID_LEN  first column tag of tile.
- num_rows  in  ROW_LEN  tile row count.
- num_cols  in  ID_LEN  tile column count.
- busy  out  1  high from the cycle after start until the cycle done asserts.
- done  out  1  one-cycle pulse when the last word has been accepted by the GIN.
- in_valid  in  1  input word valid.
- in_ready  out  1  issuer accepts the input word this cycle.
- in_data  in  VALUE_LEN  input word.
- gin_enable  out  1  to GIN enable.
- gin_ready  in  1  from GIN ready.
- gin_row_tag  out  ROW_LEN  to GIN row_tag.
- gin_col_tag  out  ID_LEN  to GIN col_tag.
- gin_value  out  VALUE_LEN  to GIN value.

Behaviour:
- Reset (rst=0, async) values:
  - State = IDLE.
  - busy, done, in_ready, gin_enable = 0.
  - gin_row_tag, gin_col_tag, gin_value = 0.
  - All counters = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1, latch all four config inputs into config registers.
  - Load row_cnt=row_base, col_cnt=col_base, and remaining-words counter = num_rows*num_cols (width ROW_LEN+ID_LEN).
  - If num_rows=0 or num_cols=0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Output register is "free" when gin_enable=0 or gin_enable&gin_ready.
  - in_ready = free, registered-path free (combinational from gin_enable/gin_ready).
  - On in_valid&in_ready:
    - gin_value <= in_data; gin_row_tag <= row_cnt; gin_col_tag <= col_cnt; gin_enable <= 1 next cycle.
    - Remaining counter decrements.
    - col_cnt increments. When col_cnt == col_base+num_cols-1, col_cnt wraps to col_base and row_cnt increments.
  - If the output register frees with no new accept, gin_enable <= 0.
  - Tag arithmetic is modulo 2^width; tags past the maximum wrap silently.
  - When the last word is accepted (remaining = 1 and accepting), go to DRAIN. in_ready is 0 from the next cycle.
- DRAIN:
  - in_ready = 0.
  - While gin_enable=1 and gin_ready=0, hold value and tags stable.
  - On gin_ready=1, deassert gin_enable and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Throughput: 1 word/cycle when in_valid and gin_ready are both continuously high. Latency from input accept to gin_enable = 1 cycle.
- Output stability: while gin_enable=1 and gin_ready=0, gin_value/tags must not change.
- Simultaneous gin_ready and new input accept in the same cycle: the old word retires and the new word loads with no bubble.
- start is ignored in ISSUE, DRAIN and DONE. Config inputs are not sampled outside the start cycle.
- Reset asserted mid-scan: all words in flight are discarded, done is not generated, state returns to IDLE.

Test Plan:
- Basic scan: row_base=2, col_base=3, num_rows=2, num_cols=3; in_data=1..6 streamed; gin_ready=1 -> (row,col,value) = (2,3,1)(2,4,2)(2,5,3)(3,3,4)(3,4,5)(3,5,6) on consecutive cycles; done pulses once after word 6.
- Backpressure: same tile; gin_ready=0 for 4 cycles while word 2 is presented -> gin_value=2 and tags (2,4) held stable; in_ready=0 during the stall; no words lost or duplicated.
- Zero size: num_cols=0, start -> no gin_enable; done pulses 2 cycles after start; busy high 1 cycle.
- Tag wrap: col_base=30, num_cols=4, num_rows=1, ID_LEN=5 -> col tags 30,31,0,1.
- Input bubbles and ignored start: in_valid toggled 1,0,1,0; start pulsed mid-scan -> gin_enable shows matching gaps; tags stay sequential; the second start has no effect.
- Reset mid-op: rst low during word 3 of 6 -> gin_enable=0, busy=0 immediately; after release and a new start, the scan restarts from (row_base,col_base).
